// File: rtl/controle_bomba.sv
// Bomb-clock game controller: arms, pauses and ticks the countdown timer,
// arbitrates expiry against defuse attempts and drives result indicators.
module controle_bomba #(
  parameter int DIV       = 5000000,
  parameter int MAX_ERROS = 3
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic       PAUSE_BTN,
  input  logic       CODIGO_VALIDO,
  input  logic       CODIGO_CORRETO,
  input  logic       TEMPO_ACABOU,
  output logic       TIMER_RESET,
  output logic       TIMER_PAUSE,
  output logic       TICK,
  output logic [1:0] ERROS,
  output logic [2:0] ESTADO,
  output logic       DESARMADA,
  output logic       EXPLODIU
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [2:0]    ERR_MAX   = 3'(MAX_ERROS);

  localparam logic [2:0] OCIOSO    = 3'd0;
  localparam logic [2:0] ARMANDO   = 3'd1;
  localparam logic [2:0] CONTANDO  = 3'd2;
  localparam logic [2:0] PAUSADO   = 3'd3;
  localparam logic [2:0] S_DESARM  = 3'd4;
  localparam logic [2:0] S_EXPLOD  = 3'd5;

  logic [2:0]    estado;
  logic [2:0]    prox;
  logic [PW-1:0] presc;
  logic [1:0]    erros;
  logic          start_q;
  logic          pause_q;
  logic          start_ev;
  logic          pause_ev;
  logic          erro_inc;
  logic          conta;

  assign start_ev = START & ~start_q;
  assign pause_ev = PAUSE_BTN & ~pause_q;

  assign ESTADO = estado;
  assign ERROS  = erros;

  always_comb begin
    prox     = estado;
    erro_inc = 1'b0;
    if (start_ev) begin
      prox = ARMANDO;
    end else begin
      case (estado)
        ARMANDO: prox = CONTANDO;
        CONTANDO: begin
          if (TEMPO_ACABOU) begin
            prox = S_EXPLOD;
          end else if (CODIGO_VALIDO && CODIGO_CORRETO) begin
            prox = S_DESARM;
          end else if (CODIGO_VALIDO) begin
            erro_inc = 1'b1;
            if ({1'b0, erros} + 3'd1 == ERR_MAX)
              prox = S_EXPLOD;
          end else if (pause_ev) begin
            prox = PAUSADO;
          end
        end
        PAUSADO: begin
          if (pause_ev)
            prox = CONTANDO;
        end
        default: prox = estado;
      endcase
    end
  end

  // Prescaler only advances while the bomb stays in CONTANDO this cycle
  assign conta = (estado == CONTANDO) && (prox == CONTANDO);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      estado      <= OCIOSO;
      presc       <= '0;
      erros       <= 2'd0;
      start_q     <= 1'b0;
      pause_q     <= 1'b0;
      TIMER_RESET <= 1'b0;
      TIMER_PAUSE <= 1'b1;
      TICK        <= 1'b0;
      DESARMADA   <= 1'b0;
      EXPLODIU    <= 1'b0;
    end else begin
      start_q     <= START;
      pause_q     <= PAUSE_BTN;
      estado      <= prox;
      TIMER_RESET <= (prox == ARMANDO);
      TIMER_PAUSE <= (prox != CONTANDO);
      DESARMADA   <= (prox == S_DESARM);
      EXPLODIU    <= (prox == S_EXPLOD);
      TICK        <= conta && (presc == PRESC_MAX);
      if (prox == ARMANDO) begin
        erros <= 2'd0;
        presc <= '0;
      end else begin
        if (erro_inc)
          erros <= erros + 2'd1;
        if (conta)
          presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_controle_bomba.sv
// Bench for controle_bomba: directed scenarios plus random stimulus
// compared every cycle against a behavioural game model.
module tb_controle_bomba;

  localparam int DIV  = 4;
  localparam int MAXE = 3;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic       PAUSE_BTN = 1'b0;
  logic       CODIGO_VALIDO = 1'b0;
  logic       CODIGO_CORRETO = 1'b0;
  logic       TEMPO_ACABOU = 1'b0;
  logic       TIMER_RESET;
  logic       TIMER_PAUSE;
  logic       TICK;
  logic [1:0] ERROS;
  logic [2:0] ESTADO;
  logic       DESARMADA;
  logic       EXPLODIU;

  controle_bomba #(.DIV(DIV), .MAX_ERROS(MAXE)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .START(START),
    .PAUSE_BTN(PAUSE_BTN),
    .CODIGO_VALIDO(CODIGO_VALIDO),
    .CODIGO_CORRETO(CODIGO_CORRETO),
    .TEMPO_ACABOU(TEMPO_ACABOU),
    .TIMER_RESET(TIMER_RESET),
    .TIMER_PAUSE(TIMER_PAUSE),
    .TICK(TICK),
    .ERROS(ERROS),
    .ESTADO(ESTADO),
    .DESARMADA(DESARMADA),
    .EXPLODIU(EXPLODIU)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Model: game state, wrong attempts, cycles spent counting since arm
  int m_st;
  int m_err;
  int m_run;
  bit m_sp;
  bit m_pp;
  bit e_tick;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_err  = 0;
    m_run  = 0;
    m_sp   = 0;
    m_pp   = 0;
    e_tick = 0;
  endtask

  task automatic model_edge();
    bit sev;
    bit pev;
    int nst;
    if (RESET) begin
      model_reset();
      return;
    end
    sev    = START && !m_sp;
    pev    = PAUSE_BTN && !m_pp;
    m_sp   = START;
    m_pp   = PAUSE_BTN;
    nst    = m_st;
    e_tick = 0;
    if (sev) begin
      nst   = 1;
      m_err = 0;
      m_run = 0;
    end else if (m_st == 1) begin
      nst = 2;
    end else if (m_st == 2) begin
      if (TEMPO_ACABOU) nst = 5;
      else if (CODIGO_VALIDO && CODIGO_CORRETO) nst = 4;
      else if (CODIGO_VALIDO) begin
        m_err++;
        if (m_err == MAXE) nst = 5;
      end else if (pev) nst = 3;
      if (nst == 2) begin
        m_run++;
        e_tick = (m_run % DIV == 0);
      end
    end else if (m_st == 3 && pev) begin
      nst = 2;
    end
    m_st = nst;
  endtask

  task automatic compare_all();
    check("estado", 32'(ESTADO), 32'(m_st));
    check("timer_reset", 32'(TIMER_RESET), 32'(m_st == 1));
    check("timer_pause", 32'(TIMER_PAUSE), 32'(m_st != 2));
    check("tick", 32'(TICK), 32'(e_tick));
    check("erros", 32'(ERROS), 32'(m_err));
    check("desarmada", 32'(DESARMADA), 32'(m_st == 4));
    check("explodiu", 32'(EXPLODIU), 32'(m_st == 5));
  endtask

  task automatic step();
    @(posedge CLOCK);
    model_edge();
    @(negedge CLOCK);
    compare_all();
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic arm();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Called at a falling edge: reset lands between clock edges
  task automatic async_reset();
    #2 RESET = 1'b1;
    #1;
    model_reset();
    compare_all();
    step();
    RESET = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    #2 RESET = 1'b1;
    @(negedge CLOCK);
    compare_all();
    step();
    RESET = 1'b0;
    hold(3);

    // Held START: single arm, ticks every DIV cycles
    START = 1'b1;
    hold(10);
    START = 1'b0;
    hold(12);

    // Pause with the prescaler at 2, then resume
    guard = 0;
    while (m_run % DIV != 2 && guard < 20) begin
      step();
      guard++;
    end
    check("pause_align", 32'(m_run % DIV), 32'd2);
    PAUSE_BTN = 1'b1;
    step();
    PAUSE_BTN = 1'b0;
    hold(20);
    PAUSE_BTN = 1'b1;
    step();
    PAUSE_BTN = 1'b0;
    hold(6);

    // Three wrong codes explode; a fourth leaves ERROS saturated
    for (int i = 0; i < 4; i++) begin
      CODIGO_VALIDO  = 1'b1;
      CODIGO_CORRETO = 1'b0;
      step();
      CODIGO_VALIDO = 1'b0;
      hold(2);
    end
    check("erros_sat", 32'(ERROS), 32'd3);
    check("explodiu_sat", 32'(ESTADO), 32'd5);

    // One wrong then a correct code defuses
    arm();
    hold(3);
    CODIGO_VALIDO = 1'b1;
    step();
    CODIGO_CORRETO = 1'b1;
    step();
    CODIGO_VALIDO  = 1'b0;
    CODIGO_CORRETO = 1'b0;
    hold(8);
    check("defuse_state", 32'(ESTADO), 32'd4);
    check("defuse_erros", 32'(ERROS), 32'd1);

    // Expiry beats a correct code; re-arm while expiry still high
    arm();
    hold(3);
    TEMPO_ACABOU   = 1'b1;
    CODIGO_VALIDO  = 1'b1;
    CODIGO_CORRETO = 1'b1;
    step();
    CODIGO_VALIDO  = 1'b0;
    CODIGO_CORRETO = 1'b0;
    hold(2);
    check("expiry_wins", 32'(ESTADO), 32'd5);
    START = 1'b1;
    step();
    START        = 1'b0;
    TEMPO_ACABOU = 1'b0;
    step();
    check("rearm_state", 32'(ESTADO), 32'd2);
    check("rearm_erros", 32'(ERROS), 32'd0);

    // Asynchronous reset mid-count, then re-arm
    hold(5);
    async_reset();
    hold(2);
    arm();
    hold(9);

    // Random play
    for (int c = 0; c < 3000; c++) begin
      START = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 14) == 0) PAUSE_BTN = ~PAUSE_BTN;
      CODIGO_VALIDO  = ($urandom_range(0, 9) == 0);
      CODIGO_CORRETO = ($urandom_range(0, 3) == 0);
      if (START) TEMPO_ACABOU = 1'b0;
      else if ($urandom_range(0, 149) == 0) TEMPO_ACABOU = 1'b1;
      if ($urandom_range(0, 499) == 0) async_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_bomba.md
Name: controle_bomba

Overview:
- Top-level game controller for the bomb-clock design; sequences the countdown timer block.
- Generates the timer's start/restart pulse, its pause level, and a one-cycle tenth-of-second tick from the board clock.
- Arbitrates between timer expiry and defuse-code attempts, counts wrong attempts, and drives the result indicators.

Parameters:
- DIV, 5000000, board-clock cycles per tenth of a second (50 MHz / 10); minimum 2.
- MAX_ERROS, 3, wrong code attempts that cause explosion; range 1..3.

Ports:
- CLOCK  input  1  board clock; all logic on posedge.
- RESET  input  1  asynchronous, active-high; forces OCIOSO.
- START  input  1  synchronous level from KEY; rising edge arms or re-arms the bomb.
- PAUSE_BTN  input  1  synchronous level; rising edge toggles CONTANDO/PAUSADO.
- CODIGO_VALIDO  input  1  one-cycle strobe: a code was entered.
- CODIGO_CORRETO  input  1  qualifies CODIGO_VALIDO; sampled only when CODIGO_VALIDO=1.
- TEMPO_ACABOU  input  1  from the timer; level, high when the count reached 0:00,0.
- TIMER_RESET  output  1  one-cycle pulse that reloads the timer to 2:00,0 and starts it.
- TIMER_PAUSE  output  1  level; high in every state except CONTANDO.
- TICK  output  1  one-cycle pulse every DIV cycles while in CONTANDO; timer advance enable.
- ERROS  output  2  wrong attempts since the last arm; saturates at MAX_ERROS.
- ESTADO  output  3  state code: OCIOSO=0, ARMANDO=1, CONTANDO=2, PAUSADO=3, DESARMADA=4, EXPLODIU=5.
- DESARMADA  output  1  high in DESARMADA.
- EXPLODIU  output  1  high in EXPLODIU; also drives the buzzer.

Behaviour:
- All outputs are registered.
- Reset values: ESTADO=0, TIMER_RESET=0, TIMER_PAUSE=1, TICK=0, ERROS=0, DESARMADA=0, EXPLODIU=0. The prescaler and edge-detect registers also clear to 0.
- Edge detection: START and PAUSE_BTN are delayed one cycle. An event is input=1 while the previous sample=0. A held level produces exactly one event.
- START event, from any state: next state is ARMANDO. This takes priority over every other input in the same cycle.
- ARMANDO (exactly 1 cycle):
  - TIMER_RESET=1, ERROS<=0, prescaler<=0.
  - Next state is CONTANDO unconditionally.
- CONTANDO:
  - Prescaler counts 0..DIV-1 and wraps to 0.
  - TICK=1 in the cycle after the prescaler holds DIV-1. First TICK comes DIV cycles after entering CONTANDO.
  - Priority within the cycle:
    - (1) START event.
    - (2) TEMPO_ACABOU=1 -> EXPLODIU.
    - (3) CODIGO_VALIDO with CODIGO_CORRETO=1 -> DESARMADA.
    - (4) CODIGO_VALIDO with CODIGO_CORRETO=0 -> ERROS+1. If ERROS+1 == MAX_ERROS, go to EXPLODIU; else stay.
    - (5) PAUSE_BTN event -> PAUSADO.
- PAUSADO:
  - Prescaler holds its value, TICK=0, TIMER_PAUSE=1.
  - CODIGO_VALIDO is ignored; ERROS is unchanged.
  - TEMPO_ACABOU is ignored, since the timer is frozen.
  - PAUSE_BTN event -> CONTANDO; the prescaler resumes from the held value, not from 0.
- DESARMADA / EXPLODIU:
  - Terminal states; TICK=0 and TIMER_PAUSE=1.
  - All inputs except START are ignored.
  - ERROS keeps its final value for display.
- OCIOSO: waits for a START event. A TEMPO_ACABOU level left over from a previous round is ignored.
- TIMER_PAUSE deasserts in the cycle ESTADO becomes CONTANDO and reasserts in the cycle it leaves.
- ERROS never exceeds MAX_ERROS and never wraps.
- RESET mid-operation: immediate asynchronous return to reset values. The timer is held paused until the next START event.

Test Plan:
- DIV=4, START held 10 cycles -> TIMER_RESET pulses exactly once (1 cycle); ESTADO goes 1 then 2; TICK first high 4 cycles after entering CONTANDO, then every 4 cycles.
- CONTANDO: PAUSE_BTN edge when the prescaler is 2; wait 20 cycles; PAUSE_BTN edge again -> no TICK while paused, TIMER_PAUSE=1; first TICK arrives 2 cycles after resume.
- MAX_ERROS=3: three CODIGO_VALIDO strobes with CODIGO_CORRETO=0 -> ERROS goes 1, 2, 3; ESTADO=5 and EXPLODIU=1 on the third; a further strobe leaves ERROS=3.
- One wrong strobe, then a correct strobe -> ESTADO=4, DESARMADA=1, ERROS=1, TICK stops, TIMER_PAUSE=1.
- TEMPO_ACABOU=1 and a correct CODIGO_VALIDO in the same cycle -> EXPLODIU wins (ESTADO=5). START edge while TEMPO_ACABOU is still high -> ARMANDO, then CONTANDO, ERROS=0.
- RESET asserted mid-count, asynchronously between clock edges -> outputs return to reset values before the next edge; the START edge afterwards re-arms normally.
